// File: rtl/pc_pkg.sv
// Shared types and default constants for the PC sequencer.
// Imported by the sequencer top and its PC register.
package pc_pkg;

   typedef enum logic [1:0] {
      ST_BOOT,
      ST_RUN,
      ST_HALT
   } pc_state_t;

   localparam int unsigned PC_WIDTH        = 64;
   localparam logic [63:0] PC_RESET_VECTOR = 64'h0;
   localparam logic [63:0] PC_EXC_VECTOR   = 64'h80;
   localparam int unsigned PC_INC          = 4;

endpackage

// File: rtl/d_ff.sv
// Single-bit D flip-flop with asynchronous active-high reset.
// Reset value is a parameter so registers can reset to any vector.
module D_FF #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_q <= RST_VAL;
      end else begin
         o_q <= i_d;
      end
   end

endmodule

// File: rtl/pc_reg.sv
// WIDTH-wide PC register with load enable, built bit by bit from D_FF.
// Asynchronous reset loads the parameterised reset vector.
module pc_reg #(
   parameter int unsigned      WIDTH     = 64,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] w_d;

   assign w_d = i_en ? i_d : o_q;

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      D_FF #(
         .RST_VAL(RESET_VAL[g])
      ) u_ff (
         .i_clk(i_clk),
         .i_rst(i_rst),
         .i_d  (w_d[g]),
         .o_q  (o_q[g])
      );
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: BOOT/RUN/HALT FSM with prioritised next-PC select.
// Redirects (exception, branch) pulse flush; bad branch targets trap.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int unsigned      WIDTH        = PC_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VECTOR = PC_RESET_VECTOR[WIDTH-1:0],
   parameter logic [WIDTH-1:0] EXC_VECTOR   = PC_EXC_VECTOR[WIDTH-1:0],
   parameter int unsigned      INC          = PC_INC
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             br_taken,
   input  logic [WIDTH-1:0] br_target,
   input  logic             exc,
   input  logic             halt_req,
   input  logic             resume,
   output logic [WIDTH-1:0] pc_out,
   output logic [WIDTH-1:0] pc_plus_inc,
   output logic             pc_valid,
   output logic             flush,
   output logic             misalign
);

   localparam logic [WIDTH-1:0] INC_W      = WIDTH'(INC);
   localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INC - 1);

   pc_state_t        r_state;
   logic             r_valid;
   logic             r_flush;
   logic             r_misalign;
   logic [WIDTH-1:0] w_pc;
   logic [WIDTH-1:0] w_pc_inc;
   logic [WIDTH-1:0] w_pc_d;
   logic             w_pc_en;
   logic             w_misal;

   assign w_pc_inc = w_pc + INC_W;
   assign w_misal  = (br_target & ALIGN_MASK) != '0;

   // Datapath select; the FSM below applies the same priority to flags.
   always_comb begin
      w_pc_en = 1'b0;
      w_pc_d  = w_pc_inc;
      case (r_state)
         ST_RUN: begin
            if (exc) begin
               w_pc_en = 1'b1;
               w_pc_d  = EXC_VECTOR;
            end else if (br_taken) begin
               w_pc_en = 1'b1;
               w_pc_d  = w_misal ? EXC_VECTOR : br_target;
            end else if (!halt_req && !stall) begin
               w_pc_en = 1'b1;
            end
         end
         ST_HALT: begin
            if (exc) begin
               w_pc_en = 1'b1;
               w_pc_d  = EXC_VECTOR;
            end
         end
         default: begin
            w_pc_en = 1'b0;
         end
      endcase
   end

   pc_reg #(
      .WIDTH    (WIDTH),
      .RESET_VAL(RESET_VECTOR)
   ) u_pc_reg (
      .i_clk(clk),
      .i_rst(reset),
      .i_en (w_pc_en),
      .i_d  (w_pc_d),
      .o_q  (w_pc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_BOOT;
         r_valid    <= 1'b0;
         r_flush    <= 1'b0;
         r_misalign <= 1'b0;
      end else begin
         r_flush    <= 1'b0;
         r_misalign <= 1'b0;
         case (r_state)
            ST_BOOT: begin
               r_state <= ST_RUN;
               r_valid <= 1'b1;
            end
            ST_RUN: begin
               if (exc) begin
                  r_flush <= 1'b1;
               end else if (br_taken) begin
                  r_flush    <= 1'b1;
                  r_misalign <= w_misal;
               end else if (halt_req) begin
                  r_state <= ST_HALT;
                  r_valid <= 1'b0;
               end
            end
            ST_HALT: begin
               if (exc || resume) begin
                  r_state <= ST_RUN;
                  r_valid <= 1'b1;
                  r_flush <= exc;
               end
            end
            default: begin
               r_state <= ST_BOOT;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign pc_out      = w_pc;
   assign pc_plus_inc = w_pc_inc;
   assign pc_valid    = r_valid;
   assign flush       = r_flush;
   assign misalign    = r_misalign;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random traffic
// checked against a rule-level reference model.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall, br_taken, exc, halt_req, resume;
   logic [63:0] br_target;
   logic [63:0] pc_out, pc_plus_inc;
   logic        pc_valid, flush, misalign;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state: mode 0=boot, 1=run, 2=halt
   int          m_mode;
   logic [63:0] m_pc;
   logic        m_valid, m_flush, m_mis;

   pc_sequencer #(
      .WIDTH       (64),
      .RESET_VECTOR(64'h0),
      .EXC_VECTOR  (64'h80),
      .INC         (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .exc        (exc),
      .halt_req   (halt_req),
      .resume     (resume),
      .pc_out     (pc_out),
      .pc_plus_inc(pc_plus_inc),
      .pc_valid   (pc_valid),
      .flush      (flush),
      .misalign   (misalign)
   );

   always #5 clk = ~clk;

   task automatic clr_in();
      stall     = 1'b0;
      br_taken  = 1'b0;
      exc       = 1'b0;
      halt_req  = 1'b0;
      resume    = 1'b0;
      br_target = 64'h0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // leaves the DUT in RUN with PC 0
   task automatic restart();
      reset = 1'b1;
      clr_in();
      step();
      reset = 1'b0;
      step();
   endtask

   function automatic void model_step();
      m_flush = 1'b0;
      m_mis   = 1'b0;
      if (reset) begin
         m_mode  = 0;
         m_pc    = 64'h0;
         m_valid = 1'b0;
      end else if (m_mode == 0) begin
         m_mode  = 1;
         m_valid = 1'b1;
      end else if (m_mode == 1) begin
         if (exc) begin
            m_pc    = 64'h80;
            m_flush = 1'b1;
         end else if (br_taken) begin
            m_flush = 1'b1;
            if (br_target % 4 != 0) begin
               m_pc  = 64'h80;
               m_mis = 1'b1;
            end else begin
               m_pc = br_target;
            end
         end else if (halt_req) begin
            m_mode  = 2;
            m_valid = 1'b0;
         end else if (!stall) begin
            m_pc = m_pc + 4;
         end
      end else begin
         if (exc) begin
            m_pc    = 64'h80;
            m_flush = 1'b1;
            m_mode  = 1;
            m_valid = 1'b1;
         end else if (resume) begin
            m_mode  = 1;
            m_valid = 1'b1;
         end
      end
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      clr_in();
      #3;
      n_cmp += 4;
      if (pc_out !== 64'h0) begin
         n_err++; $display("FAIL rst_pc got %h want 0", pc_out);
      end
      if (pc_valid !== 1'b0) begin
         n_err++; $display("FAIL rst_valid got %b want 0", pc_valid);
      end
      if (flush !== 1'b0) begin
         n_err++; $display("FAIL rst_flush got %b want 0", flush);
      end
      if (misalign !== 1'b0) begin
         n_err++; $display("FAIL rst_mis got %b want 0", misalign);
      end
      step();
      n_cmp++;
      if (pc_out !== 64'h0 || pc_valid !== 1'b0) begin
         n_err++;
         $display("FAIL rst_held got pc=%h v=%b want 0/0", pc_out, pc_valid);
      end
   endtask

   task automatic test_sequential();
      logic [63:0] e_pc[5];
      logic        e_v[5];
      e_pc[0] = 64'd0; e_pc[1] = 64'd0; e_pc[2] = 64'd4;
      e_pc[3] = 64'd8; e_pc[4] = 64'd12;
      e_v[0] = 1'b0; e_v[1] = 1'b1; e_v[2] = 1'b1;
      e_v[3] = 1'b1; e_v[4] = 1'b1;
      reset = 1'b1;
      clr_in();
      step();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) step();
         n_cmp++;
         if (pc_out !== e_pc[i] || pc_valid !== e_v[i]) begin
            n_err++;
            $display("FAIL seq[%0d] got pc=%h v=%b want pc=%h v=%b",
                     i, pc_out, pc_valid, e_pc[i], e_v[i]);
         end
      end
   endtask

   task automatic test_stall_branch();
      restart();
      step();
      step();
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         n_cmp++;
         if (pc_out !== 64'd8 || flush !== 1'b0 || pc_valid !== 1'b1) begin
            n_err++;
            $display("FAIL stall[%0d] got pc=%h f=%b v=%b want 8/0/1",
                     i, pc_out, flush, pc_valid);
         end
      end
      stall     = 1'b0;
      br_taken  = 1'b1;
      br_target = 64'h1000;
      step();
      n_cmp++;
      if (pc_out !== 64'h1000 || flush !== 1'b1 || misalign !== 1'b0) begin
         n_err++;
         $display("FAIL branch got pc=%h f=%b m=%b want 1000/1/0",
                  pc_out, flush, misalign);
      end
      clr_in();
      step();
      n_cmp++;
      if (pc_out !== 64'h1004 || flush !== 1'b0) begin
         n_err++;
         $display("FAIL after_br got pc=%h f=%b want 1004/0", pc_out, flush);
      end
   endtask

   task automatic test_misalign();
      restart();
      stall     = 1'b1;
      br_taken  = 1'b1;
      br_target = 64'h1002;
      step();
      n_cmp++;
      if (pc_out !== 64'h80 || flush !== 1'b1 || misalign !== 1'b1) begin
         n_err++;
         $display("FAIL misal got pc=%h f=%b m=%b want 80/1/1",
                  pc_out, flush, misalign);
      end
      clr_in();
      step();
      n_cmp++;
      if (pc_out !== 64'h84 || flush !== 1'b0 || misalign !== 1'b0) begin
         n_err++;
         $display("FAIL misal_end got pc=%h f=%b m=%b want 84/0/0",
                  pc_out, flush, misalign);
      end
   endtask

   task automatic test_back_to_back();
      restart();
      exc = 1'b1;
      step();
      exc       = 1'b0;
      br_taken  = 1'b1;
      br_target = 64'h400;
      step();
      n_cmp++;
      if (pc_out !== 64'h400 || flush !== 1'b1) begin
         n_err++;
         $display("FAIL b2b got pc=%h f=%b want 400/1", pc_out, flush);
      end
   endtask

   task automatic test_halt();
      restart();
      for (int i = 0; i < 4; i++) step();
      halt_req = 1'b1;
      step();
      n_cmp++;
      if (pc_out !== 64'd16 || pc_valid !== 1'b0) begin
         n_err++;
         $display("FAIL halt got pc=%h v=%b want 10/0", pc_out, pc_valid);
      end
      halt_req  = 1'b0;
      br_taken  = 1'b1;
      br_target = 64'h2000;
      stall     = 1'b1;
      step();
      n_cmp++;
      if (pc_out !== 64'd16 || pc_valid !== 1'b0 || flush !== 1'b0) begin
         n_err++;
         $display("FAIL halt_br got pc=%h v=%b f=%b want 10/0/0",
                  pc_out, pc_valid, flush);
      end
      clr_in();
      resume = 1'b1;
      step();
      n_cmp++;
      if (pc_out !== 64'd16 || pc_valid !== 1'b1 || flush !== 1'b0) begin
         n_err++;
         $display("FAIL resume got pc=%h v=%b f=%b want 10/1/0",
                  pc_out, pc_valid, flush);
      end
      resume = 1'b0;
      step();
      n_cmp++;
      if (pc_out !== 64'd20 || pc_valid !== 1'b1) begin
         n_err++;
         $display("FAIL post_res got pc=%h v=%b want 14/1", pc_out, pc_valid);
      end
      halt_req = 1'b1;
      resume   = 1'b1;
      step();
      n_cmp++;
      if (pc_out !== 64'd20 || pc_valid !== 1'b0) begin
         n_err++;
         $display("FAIL halt_res got pc=%h v=%b want 14/0", pc_out, pc_valid);
      end
      clr_in();
      exc = 1'b1;
      step();
      n_cmp++;
      if (pc_out !== 64'h80 || pc_valid !== 1'b1 || flush !== 1'b1) begin
         n_err++;
         $display("FAIL halt_exc got pc=%h v=%b f=%b want 80/1/1",
                  pc_out, pc_valid, flush);
      end
      clr_in();
   endtask

   task automatic test_wrap();
      restart();
      br_taken  = 1'b1;
      br_target = 64'hFFFF_FFFF_FFFF_FFFC;
      step();
      n_cmp++;
      if (pc_out !== 64'hFFFF_FFFF_FFFF_FFFC || pc_plus_inc !== 64'h0) begin
         n_err++;
         $display("FAIL wrap_top got pc=%h inc=%h want fff..fc/0",
                  pc_out, pc_plus_inc);
      end
      clr_in();
      step();
      n_cmp++;
      if (pc_out !== 64'h0 || pc_plus_inc !== 64'h4 ||
          flush !== 1'b0 || misalign !== 1'b0) begin
         n_err++;
         $display("FAIL wrap got pc=%h inc=%h f=%b m=%b want 0/4/0/0",
                  pc_out, pc_plus_inc, flush, misalign);
      end
   endtask

   task automatic test_async_reset();
      restart();
      step();
      step();
      halt_req = 1'b1;
      step();
      halt_req = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      n_cmp++;
      if (pc_out !== 64'h0 || pc_valid !== 1'b0 || flush !== 1'b0) begin
         n_err++;
         $display("FAIL async_rst got pc=%h v=%b f=%b want 0/0/0",
                  pc_out, pc_valid, flush);
      end
      step();
      reset = 1'b0;
      step();
      n_cmp++;
      if (pc_out !== 64'h0 || pc_valid !== 1'b1) begin
         n_err++;
         $display("FAIL rst_boot got pc=%h v=%b want 0/1", pc_out, pc_valid);
      end
   endtask

   task automatic test_random();
      restart();
      m_mode  = 1;
      m_pc    = 64'h0;
      m_valid = 1'b1;
      m_flush = 1'b0;
      m_mis   = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         reset     = ($urandom_range(0, 199) == 0);
         exc       = ($urandom_range(0, 15) == 0);
         br_taken  = ($urandom_range(0, 3) == 0);
         halt_req  = ($urandom_range(0, 11) == 0);
         stall     = ($urandom_range(0, 3) == 0);
         resume    = ($urandom_range(0, 3) == 0);
         br_target = {$urandom, $urandom};
         if ($urandom_range(0, 3) != 0) br_target[1:0] = 2'b00;
         step();
         model_step();
         n_cmp++;
         if (pc_out !== m_pc || pc_valid !== m_valid ||
             flush !== m_flush || misalign !== m_mis ||
             pc_plus_inc !== m_pc + 64'd4) begin
            n_err++;
            $display("FAIL rand[%0d] got pc=%h v=%b f=%b m=%b want pc=%h v=%b f=%b m=%b",
                     i, pc_out, pc_valid, flush, misalign,
                     m_pc, m_valid, m_flush, m_mis);
         end
      end
      clr_in();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      clr_in();
      test_reset();
      test_sequential();
      test_stall_branch();
      test_misalign();
      test_back_to_back();
      test_halt();
      test_wrap();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, 64, PC width in bits (16..64).
REQ-002 Parameter RESET_VECTOR, 0, PC value loaded by reset.
REQ-003 Parameter EXC_VECTOR, 'h80, PC value loaded on exception or misaligned redirect.
REQ-004 Parameter INC, 4, sequential increment; power of two, at most 8.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 stall  input  1  hold current PC this cycle.
REQ-008 br_taken  input  1  redirect PC to br_target.
REQ-009 br_target  input  WIDTH  redirect destination.
REQ-010 exc  input  1  exception; redirect to EXC_VECTOR.
REQ-011 halt_req  input  1  enter HALT.
REQ-012 resume  input  1  leave HALT.
REQ-013 pc_out  output  WIDTH  registered current PC.
REQ-014 pc_plus_inc  output  WIDTH  combinational pc_out+INC, modulo 2^WIDTH.
REQ-015 pc_valid  output  1  registered; pc_out is a valid fetch address.
REQ-016 flush  output  1  registered; one-cycle pulse in the first cycle a redirected PC is presented.
REQ-017 misalign  output  1  registered; one-cycle pulse when a br_target was not INC-aligned.

Function
REQ-018 The FSM SHALL have states BOOT, RUN and HALT.
REQ-019 In BOOT, pc_out SHALL equal RESET_VECTOR and pc_valid SHALL be 0; the first rising edge after reset deassertion SHALL move the FSM to RUN with the PC unchanged.
REQ-020 In RUN, the next PC SHALL be selected by priority: exc > br_taken > halt_req > stall > increment.
REQ-021 exc SHALL load EXC_VECTOR and pulse flush.
REQ-022 br_taken with an aligned target SHALL load br_target and pulse flush.
REQ-023 br_taken with a target whose low log2(INC) bits are nonzero SHALL load EXC_VECTOR and pulse both flush and misalign.
REQ-024 br_taken and exc SHALL both override stall.
REQ-025 halt_req SHALL hold the PC, enter HALT and drive pc_valid 0 from the next cycle.
REQ-026 stall SHALL hold the PC with pc_valid held at 1.
REQ-027 Increment SHALL load pc_out+INC; the result SHALL wrap modulo 2^WIDTH with no flag.
REQ-028 In HALT, the PC SHALL be held and br_taken, stall and halt_req SHALL be ignored.
REQ-029 In HALT, exc SHALL load EXC_VECTOR, pulse flush and enter RUN.
REQ-030 In HALT, resume without exc SHALL enter RUN with the PC unchanged and pc_valid 1 on the next cycle.
REQ-031 Simultaneous halt_req and resume in RUN SHALL be treated as halt_req.
REQ-032 flush and misalign SHALL each be high for exactly one cycle per event; back-to-back redirects SHALL keep flush high on consecutive cycles.

Reset
REQ-033 While reset is high, regardless of clk: pc_out=RESET_VECTOR, state=BOOT, pc_valid=0, flush=0, misalign=0.
REQ-034 Reset asserted mid-operation, including in HALT or during a redirect, SHALL abandon all pending state.

Structure
REQ-035 Package pc_pkg SHALL hold the state enum pc_state_t and the default parameter constants.
REQ-036 The PC storage SHALL be sub-module pc_reg: a WIDTH-wide register with asynchronous reset to a parameterised value and a load enable, built from the existing D_FF cell.
REQ-037 Next-PC selection and the FSM SHALL live in pc_sequencer.

Verification (WIDTH=64, RESET_VECTOR=0, EXC_VECTOR='h80, INC=4)
REQ-038 Release reset, idle for 4 cycles -> pc_out sequence 0 (BOOT, pc_valid=0), 0, 4, 8, 12 with pc_valid=1 from RUN onward.
REQ-039 In RUN at PC=8: stall for 2 cycles, then br_taken with target 'h1000 -> PC 8, 8, 'h1000; flush=1 only in the 'h1000 cycle.
REQ-040 br_taken with target 'h1002 together with stall -> PC='h80, flush=1 and misalign=1 for exactly one cycle.
REQ-041 halt_req at PC=16, then br_taken, then resume -> PC stays 16 with pc_valid=0; after resume, PC 16 then 20 with pc_valid=1.
REQ-042 Force PC to 'hFFFF_FFFF_FFFF_FFFC via a branch, then increment -> pc_out=0 with no flag; pc_plus_inc=4.
REQ-043 Assert reset asynchronously mid-cycle while in HALT -> pc_out=0 and pc_valid=0 immediately, before the next clk edge.
